// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - single-clock FIFO with standard or first-word-fall-through read
module sync_fifo_fwft #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = 28,
    parameter int AE_THRESH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LVL_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LVL_AF   = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] LVL_AE   = (ADDR_WIDTH+1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);

    generate
        if (AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH) begin : g_bad_thresholds
            $error("sync_fifo_fwft: thresholds must satisfy 0 <= AE_THRESH < AF_THRESH <= DEPTH");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [ADDR_WIDTH:0]   w_level;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    // Occupancy is the pointer distance; pointers carry one extra wrap bit so
    // full (distance DEPTH) and empty (distance 0) are distinguishable.
    assign w_level  = r_wr_ptr - r_rd_ptr;
    assign w_full   = (w_level == LVL_FULL);
    assign w_empty  = (w_level == '0);

    // Flush wins over both requests in the same cycle.
    assign w_wr_acc = wr_en && !w_full  && !flush;
    assign w_rd_acc = rd_en && !w_empty && !flush;

    assign level        = w_level;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (w_level >= LVL_AF);
    assign almost_empty = (w_level <= LVL_AE);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Pointer advance on accepted accesses; flush returns both to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Sticky error flags, cleared only by flush or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && w_full)  r_overflow  <= 1'b1;
            if (rd_en && w_empty) r_underflow <= 1'b1;
        end
    end

    // Storage array; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented as soon as it is stored.
            assign rd_data  = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
            assign rd_valid = !w_empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_rd_data;
            logic                  r_rd_valid;

            // Registered read: one-cycle valid pulse per pop, data held otherwise.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
                end
            end

            assign rd_data  = r_rd_data;
            assign rd_valid = r_rd_valid;
        end
    endgenerate
endmodule
